// File: rtl/axil_line_master_pkg.sv
// Shared constants and state encoding for the AXI-Lite line master.
package axil_line_master_pkg;

  localparam logic [31:0] AXI_OKAY         = 32'h0;
  localparam int          LINE_BYTES       = 16;
  localparam logic [31:0] LINE_OFFSET_MASK = 32'(LINE_BYTES - 1);

  typedef logic [2:0] lineState_t;

  localparam lineState_t ST_IDLE  = 3'd0;
  localparam lineState_t ST_RD_A  = 3'd1;
  localparam lineState_t ST_RD_D  = 3'd2;
  localparam lineState_t ST_WR_AW = 3'd3;
  localparam lineState_t ST_WR_B  = 3'd4;
  localparam lineState_t ST_RESP  = 3'd5;

endpackage

// File: rtl/axil_wr_chan_tracker.sv
// Drives AW and W valids for one write; each drops on its own handshake and stays low.
module axil_wr_chan_tracker (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic awReady,
  input  logic wReady,
  output logic awValid,
  output logic wValid,
  output logic bothDone
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awValid <= 1'b0;
      wValid  <= 1'b0;
    end else if (start) begin
      awValid <= 1'b1;
      wValid  <= 1'b1;
    end else begin
      if (awValid && awReady) awValid <= 1'b0;
      if (wValid && wReady)   wValid  <= 1'b0;
    end
  end

  // A channel whose valid is already low finished its handshake earlier in this write.
  assign bothDone = (!awValid || awReady) && (!wValid || wReady);

endmodule

// File: rtl/axil_line_master.sv
// AXI-Lite initiator turning one 128-bit line request into an AR/R or AW/W/B exchange.
// state  | meaning
// IDLE   | req_ready high, waiting for a client request
// RD_A   | AR valid, waiting for readAddr_ready
// RD_D   | R ready, waiting for read data
// WR_AW  | AW and W outstanding, each dropped on its own handshake
// WR_B   | B ready, waiting for write status
// RESP   | result held on the response port until resp_ready
module axil_line_master
  import axil_line_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int ALIGN_CHK = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   readAddr_addr,
  output logic                readAddr_valid,
  input  logic                readAddr_ready,
  input  logic [DATA_W-1:0]   readData_data,
  input  logic                readData_valid,
  output logic                readData_ready,
  output logic [ADDR_W-1:0]   writeAddr_addr,
  output logic                writeAddr_valid,
  input  logic                writeAddr_ready,
  output logic [DATA_W-1:0]   writeData_data,
  output logic [DATA_W/8-1:0] writeData_strb,
  output logic                writeData_valid,
  input  logic                writeData_ready,
  input  logic [31:0]         writeResp_msg,
  input  logic                writeResp_valid,
  output logic                writeResp_ready
);

  lineState_t        state;
  logic [ADDR_W-1:0] addrReg;
  logic              unaligned;
  logic              wrStart;
  logic              wrDone;

  assign req_ready      = (state == ST_IDLE);
  assign readAddr_addr  = addrReg;
  assign writeAddr_addr = addrReg;
  assign unaligned      = (ALIGN_CHK != 0) && ((req_addr & ADDR_W'(LINE_OFFSET_MASK)) != '0);
  assign wrStart        = req_ready && req_valid && req_we && !unaligned;

  axil_wr_chan_tracker wrTracker (
    .clk      (clk),
    .rst      (rst),
    .start    (wrStart),
    .awReady  (writeAddr_ready),
    .wReady   (writeData_ready),
    .awValid  (writeAddr_valid),
    .wValid   (writeData_valid),
    .bothDone (wrDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      addrReg         <= '0;
      writeData_data  <= '0;
      writeData_strb  <= '0;
      readAddr_valid  <= 1'b0;
      readData_ready  <= 1'b0;
      writeResp_ready <= 1'b0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addrReg        <= req_addr;
            writeData_data <= req_wdata;
            writeData_strb <= req_strb;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            if (unaligned) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (req_we) begin
              state <= ST_WR_AW;
            end else begin
              readAddr_valid <= 1'b1;
              state          <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          if (readAddr_ready) begin
            readAddr_valid <= 1'b0;
            readData_ready <= 1'b1;
            state          <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (readData_valid) begin
            resp_rdata     <= readData_data;
            resp_err       <= 1'b0;
            readData_ready <= 1'b0;
            resp_valid     <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_WR_AW: begin
          if (wrDone) begin
            writeResp_ready <= 1'b1;
            state           <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (writeResp_valid) begin
            resp_err        <= (writeResp_msg != AXI_OKAY);
            writeResp_ready <= 1'b0;
            resp_valid      <= 1'b1;
            state           <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_line_master.sv
// Self-checking bench: behavioural AXI-Lite slave with configurable delays plus a line-memory reference model.
module tb_axil_line_master;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;
  logic [15:0]   req_strb = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [127:0]  resp_rdata;
  logic          resp_err;
  logic [31:0]   readAddr_addr;
  logic          readAddr_valid;
  logic          readAddr_ready = 1'b0;
  logic [127:0]  readData_data = '0;
  logic          readData_valid = 1'b0;
  logic          readData_ready;
  logic [31:0]   writeAddr_addr;
  logic          writeAddr_valid;
  logic          writeAddr_ready = 1'b0;
  logic [127:0]  writeData_data;
  logic [15:0]   writeData_strb;
  logic          writeData_valid;
  logic          writeData_ready = 1'b0;
  logic [31:0]   writeResp_msg = '0;
  logic          writeResp_valid = 1'b0;
  logic          writeResp_ready;

  axil_line_master #(.ADDR_W(32), .DATA_W(128), .ALIGN_CHK(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb), .writeData_valid(writeData_valid),
    .writeData_ready(writeData_ready),
    .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration and bookkeeping
  int          cfgArD = 0, cfgRD = 0, cfgAwD = 0, cfgWD = 0, cfgBD = 0;
  logic [31:0] cfgMsg = '0;
  logic [127:0] slaveMem [logic [31:0]];
  logic [127:0] refMem   [logic [31:0]];
  int          rPend = -1, bPend = -1, arCnt = 0, awCnt = 0, wCnt = 0;
  logic        gotAw = 1'b0, gotW = 1'b0;
  logic [31:0] rAddr = '0, awAddrCap = '0;
  logic [127:0] wDataCap = '0;
  logic [15:0] wStrbCap = '0;
  int          arHs = 0, awHs = 0, wHs = 0, bHs = 0, reassertErr = 0, busActivity = 0;

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [15:0] st);
    logic [127:0] r;
    r = old;
    for (int i = 0; i < 16; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Slave decides its outputs mid-cycle; a handshake happens at the next posedge iff valid&ready now.
  always @(negedge clk) begin
    if (rst) begin
      readAddr_ready = 0; readData_valid = 0; writeAddr_ready = 0; writeData_ready = 0; writeResp_valid = 0;
      rPend = -1; bPend = -1; arCnt = 0; awCnt = 0; wCnt = 0; gotAw = 0; gotW = 0;
    end else begin
      if (readAddr_valid || writeAddr_valid || writeData_valid) busActivity++;
      if (rPend > 0) begin
        rPend--; readData_valid = 0;
      end else if (rPend == 0) begin
        readData_valid = 1;
        readData_data  = slaveMem.exists(rAddr) ? slaveMem[rAddr] : '0;
        if (readData_ready) rPend = -1;
      end else readData_valid = 0;
      readAddr_ready = 0;
      if (readAddr_valid) begin
        if (arCnt >= cfgArD) begin
          readAddr_ready = 1; arHs++; rAddr = readAddr_addr; rPend = cfgRD; arCnt = 0;
        end else arCnt++;
      end
      if (bPend > 0) begin
        bPend--; writeResp_valid = 0;
      end else if (bPend == 0) begin
        writeResp_valid = 1; writeResp_msg = cfgMsg;
        if (writeResp_ready) begin bHs++; bPend = -1; end
      end else writeResp_valid = 0;
      writeAddr_ready = 0;
      if (writeAddr_valid) begin
        if (gotAw) reassertErr++;
        else if (awCnt >= cfgAwD) begin
          writeAddr_ready = 1; awHs++; gotAw = 1; awAddrCap = writeAddr_addr; awCnt = 0;
        end else awCnt++;
      end
      writeData_ready = 0;
      if (writeData_valid) begin
        if (gotW) reassertErr++;
        else if (wCnt >= cfgWD) begin
          writeData_ready = 1; wHs++; gotW = 1; wDataCap = writeData_data; wStrbCap = writeData_strb; wCnt = 0;
        end else wCnt++;
      end
      if (gotAw && gotW) begin
        if (cfgMsg == 0)
          slaveMem[awAddrCap] = merge(slaveMem.exists(awAddrCap) ? slaveMem[awAddrCap] : '0, wDataCap, wStrbCap);
        bPend = cfgBD; gotAw = 0; gotW = 0;
      end
    end
  end

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [127:0] wd, input logic [15:0] st,
                           output logic [127:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_strb = st; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic release_resp();
    @(negedge clk); resp_ready = 1;
    @(posedge clk); #1; resp_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    vectors++;
    if ({readAddr_valid, writeAddr_valid, writeData_valid, readData_ready, writeResp_ready, resp_valid, resp_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0000000",
               {readAddr_valid, writeAddr_valid, writeData_valid, readData_ready, writeResp_ready, resp_valid, resp_err});
    end
    vectors++;
    if (resp_rdata !== 128'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    vectors++;
    if (readAddr_addr !== 32'h0 || writeData_data !== 128'h0 || writeData_strb !== 16'h0) begin
      miscompares++; $display("FAIL reset_regs got addr %h data %h strb %h exp 0", readAddr_addr, writeData_data, writeData_strb);
    end
  endtask

  task automatic test_read_basic();
    logic [127:0] rd, data;
    logic er;
    int lat, arBefore;
    data = 128'h0F0E0D0C0B0A09080706050403020100;
    slaveMem[32'h40] = data; refMem[32'h40] = data;
    cfgArD = 0; cfgRD = 0; cfgAwD = 0; cfgWD = 0; cfgBD = 0; cfgMsg = 0;
    arBefore = arHs;
    drive_req(1'b0, 32'h40, '0, '0, rd, er, lat);
    vectors++; if (rd !== data) begin miscompares++; $display("FAIL rd_basic_data got %h exp %h", rd, data); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rd_basic_err got %b exp 0", er); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_basic_latency got %0d exp 3", lat); end
    vectors++; if (rAddr !== 32'h40) begin miscompares++; $display("FAIL rd_basic_araddr got %h exp 40", rAddr); end
    vectors++; if (arHs - arBefore !== 1) begin miscompares++; $display("FAIL rd_basic_ar_count got %0d exp 1", arHs - arBefore); end
    release_resp();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rd_basic_release got valid %b ready %b exp 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_write_staggered();
    logic [127:0] rd, wd;
    logic er;
    int lat, awB, wB, bB, reB;
    wd = {$urandom, $urandom, $urandom, $urandom};
    refMem[32'h100] = merge(refMem.exists(32'h100) ? refMem[32'h100] : '0, wd, 16'h00FF);
    cfgAwD = 1; cfgWD = 3; cfgBD = 0; cfgMsg = 0;
    awB = awHs; wB = wHs; bB = bHs; reB = reassertErr;
    drive_req(1'b1, 32'h100, wd, 16'h00FF, rd, er, lat);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wr_stag_err got %b exp 0", er); end
    vectors++; if (rd !== 128'h0) begin miscompares++; $display("FAIL wr_stag_rdata got %h exp 0", rd); end
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL wr_stag_latency got %0d exp 6", lat); end
    vectors++;
    if (awHs - awB !== 1 || wHs - wB !== 1 || bHs - bB !== 1) begin
      miscompares++; $display("FAIL wr_stag_hs_counts got aw %0d w %0d b %0d exp 1 1 1", awHs - awB, wHs - wB, bHs - bB);
    end
    vectors++; if (reassertErr !== reB) begin miscompares++; $display("FAIL wr_stag_reassert got %0d exp 0", reassertErr - reB); end
    vectors++;
    if (slaveMem[32'h100] !== refMem[32'h100]) begin
      miscompares++; $display("FAIL wr_stag_mem got %h exp %h", slaveMem[32'h100], refMem[32'h100]);
    end
    release_resp();
    cfgAwD = 0; cfgWD = 0;
  endtask

  task automatic test_write_error();
    logic [127:0] rd;
    logic er;
    int lat;
    cfgMsg = 32'h2;
    drive_req(1'b1, 32'h100, {4{32'hDEADBEEF}}, 16'hFFFF, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL wr_err_flag got %b exp 1", er); end
    vectors++; if (rd !== 128'h0) begin miscompares++; $display("FAIL wr_err_rdata got %h exp 0", rd); end
    release_resp();
    cfgMsg = 0;
    drive_req(1'b0, 32'h100, '0, '0, rd, er, lat);
    vectors++; if (rd !== refMem[32'h100]) begin miscompares++; $display("FAIL rd_after_err_data got %h exp %h", rd, refMem[32'h100]); end
    vectors++; if (er !== 1'b0 || lat !== 3) begin miscompares++; $display("FAIL rd_after_err got err %b lat %0d exp 0 3", er, lat); end
    release_resp();
  endtask

  task automatic test_unaligned();
    logic [127:0] rd;
    logic er;
    int lat, busBefore;
    busBefore = busActivity;
    drive_req(1'b1, 32'h104, {4{32'h12345678}}, 16'hFFFF, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL unaligned_err got %b exp 1", er); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL unaligned_latency got %0d exp 1", lat); end
    vectors++; if (rd !== 128'h0) begin miscompares++; $display("FAIL unaligned_rdata got %h exp 0", rd); end
    release_resp();
    @(negedge clk); #1;
    vectors++; if (busActivity !== busBefore) begin miscompares++; $display("FAIL unaligned_bus got %0d valid cycles exp 0", busActivity - busBefore); end
  endtask

  task automatic test_resp_hold();
    logic [127:0] rd;
    logic er;
    int lat, busBefore, badCycles;
    drive_req(1'b0, 32'h40, '0, '0, rd, er, lat);
    req_we = 0; req_addr = 32'h80; req_valid = 1;
    busBefore = busActivity; badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== refMem[32'h40] || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable cyc %0d got v %b d %h e %b rr %b exp 1 %h 0 0", i, resp_valid, resp_rdata, resp_err, req_ready, refMem[32'h40]);
      end
    end
    req_valid = 0;
    vectors++; if (busActivity !== busBefore) begin miscompares++; $display("FAIL hold_bus got %0d valid cycles exp 0", busActivity - busBefore); end
    release_resp();
  endtask

  task automatic test_reset_mid();
    int n, seen;
    cfgRD = 1000;
    @(negedge clk); req_we = 0; req_addr = 32'h40; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    n = 0;
    while (readData_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++; if (readData_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_reach_rd_d got %b exp 1", readData_ready); end
    #2 rst = 1;
    #1;
    vectors++;
    if (readData_ready !== 1'b0 || readAddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_async got rready %b arvalid %b exp 0 0", readData_ready, readAddr_valid);
    end
    @(negedge clk); @(negedge clk); rst = 0; #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_ready got %b exp 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rstmid_no_resp got %0d cycles exp 0", seen); end
    cfgRD = 0;
  endtask

  task automatic test_random_back_to_back();
    logic [127:0] rd, wd, expRd;
    logic [31:0] addr, msg;
    logic [15:0] st;
    logic we, er, expErr;
    int lat, expLat, hold;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 31)) << 4;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      st = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      msg = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
      cfgArD = $urandom_range(0, 3); cfgRD = $urandom_range(0, 3);
      cfgAwD = $urandom_range(0, 3); cfgWD = $urandom_range(0, 3); cfgBD = $urandom_range(0, 3);
      cfgMsg = msg;
      if (addr[3:0] != 4'h0) begin
        expErr = 1; expRd = '0; expLat = 1;
      end else if (we) begin
        expErr = (msg != 0); expRd = '0;
        expLat = 3 + ((cfgAwD > cfgWD) ? cfgAwD : cfgWD) + cfgBD;
        if (msg == 0) refMem[addr] = merge(refMem.exists(addr) ? refMem[addr] : '0, wd, st);
      end else begin
        expErr = 0; expRd = refMem.exists(addr) ? refMem[addr] : '0;
        expLat = 3 + cfgArD + cfgRD;
      end
      drive_req(we, addr, wd, st, rd, er, lat);
      vectors++; if (rd !== expRd) begin miscompares++; $display("FAIL rand%0d_rdata we %b addr %h got %h exp %h", t, we, addr, rd, expRd); end
      vectors++; if (er !== expErr) begin miscompares++; $display("FAIL rand%0d_err we %b addr %h got %b exp %b", t, we, addr, er, expErr); end
      vectors++; if (lat !== expLat) begin miscompares++; $display("FAIL rand%0d_latency we %b addr %h got %0d exp %0d", t, we, addr, lat, expLat); end
      hold = $urandom_range(0, 2);
      repeat (hold) begin @(posedge clk); #1; end
      release_resp();
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rand%0d_release got %b exp 0", t, resp_valid); end
    end
    cfgArD = 0; cfgRD = 0; cfgAwD = 0; cfgWD = 0; cfgBD = 0; cfgMsg = 0;
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_read_basic();
    test_write_staggered();
    test_write_error();
    test_unaligned();
    test_resp_hold();
    test_reset_mid();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
